// File: rtl/perf_mon_pkg.sv
// Shared types for the performance event monitor: run-control states and counter indices.
package perf_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } mon_state_e;

  // Slot 0 of the counter bank is the elapsed-cycle counter; events follow at 1..NUM_EVT.
  localparam int unsigned CYC_IDX = 0;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with a sticky overflow flag; clr has priority over inc.
module perf_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_reg;
  logic             at_max;

  assign at_max = &cnt_reg;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (clr) begin
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (inc) begin
      // An increment attempted at full scale leaves the value pinned and flags it.
      if (at_max) begin
        ovf_reg <= 1'b1;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign cnt = cnt_reg;
  assign ovf = ovf_reg;

endmodule

// File: rtl/perf_event_monitor.sv
// Run-control FSM, saturating cycle/event counters, shadow snapshot bank and
// zero-latency readout mux for the CPU performance monitor.
module perf_event_monitor
  import perf_mon_pkg::*;
#(
  parameter  int unsigned NUM_EVT = 2,
  parameter  int unsigned CNT_W   = 32,
  parameter  int unsigned LIMIT   = 30,
  localparam int unsigned SEL_W   = $clog2(NUM_EVT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               snap_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               rd_ovf_o,
  output logic               running_o,
  output logic               done_o
);

  localparam int unsigned      NCNT     = NUM_EVT + 1;
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(LIMIT - 1);

  mon_state_e       state_reg, state_next;
  logic             count_en;
  logic             hit_limit;
  logic [NCNT-1:0]  inc_vec;

  logic [CNT_W-1:0] live_cnt       [NCNT];
  logic             live_ovf       [NCNT];
  logic [CNT_W-1:0] shadow_cnt_reg [NCNT];
  logic             shadow_ovf_reg [NCNT];

  // The counted cycle that brings the cycle counter to LIMIT is the last one.
  assign hit_limit = (LIMIT != 0) && (live_cnt[CYC_IDX] == LIMIT_M1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_en   = 1'b0;
    if (clear_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            count_en   = 1'b1;
            state_next = hit_limit ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (start_i) begin
            count_en = 1'b1;
            if (hit_limit) begin
              state_next = ST_DONE;
            end
          end
        end
        ST_DONE: state_next = ST_DONE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign running_o = (state_reg == ST_RUN) && start_i;
  assign done_o    = (state_reg == ST_DONE);

  assign inc_vec[CYC_IDX] = count_en;

  generate
    for (genvar gi = 1; gi < NCNT; gi++) begin : g_evt_inc
      assign inc_vec[gi] = count_en & evt_i[gi-1];
    end

    for (genvar gi = 0; gi < NCNT; gi++) begin : g_cnt
      perf_sat_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr     (clear_i),
        .inc     (inc_vec[gi]),
        .cnt     (live_cnt[gi]),
        .ovf     (live_ovf[gi])
      );

      // A snapshot taken alongside clear_i still sees the pre-clear live values.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          shadow_cnt_reg[gi] <= '0;
          shadow_ovf_reg[gi] <= 1'b0;
        end else if (snap_i) begin
          shadow_cnt_reg[gi] <= live_cnt[gi];
          shadow_ovf_reg[gi] <= live_ovf[gi];
        end else if (clear_i) begin
          shadow_cnt_reg[gi] <= '0;
          shadow_ovf_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    rd_data_o = '0;
    rd_ovf_o  = 1'b0;
    for (int k = 0; k < NCNT; k++) begin
      if (rd_sel_i == SEL_W'(k)) begin
        rd_data_o = shadow_cnt_reg[k];
        rd_ovf_o  = shadow_ovf_reg[k];
      end
    end
  end

endmodule

// File: tb/tb_perf_event_monitor.sv
// Self-checking bench: two monitors (LIMIT=30 and LIMIT=0) on shared stimulus, readouts via a scoreboard.
`timescale 1ns/1ps
module tb_perf_event_monitor;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       start_i, clear_i, snap_i;
  logic [1:0] evt_i;
  logic [1:0] rd_sel_i;
  logic [7:0] rd_data, rd_data0;
  logic       rd_ovf, rd_ovf0, running, running0, done, done0;

  always #5 clk_i = ~clk_i;

  perf_event_monitor #(.NUM_EVT(2), .CNT_W(8), .LIMIT(30)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .clear_i(clear_i),
    .evt_i(evt_i), .snap_i(snap_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd_data),
    .rd_ovf_o(rd_ovf), .running_o(running), .done_o(done)
  );

  perf_event_monitor #(.NUM_EVT(2), .CNT_W(8), .LIMIT(0)) dut0 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .clear_i(clear_i),
    .evt_i(evt_i), .snap_i(snap_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd_data0),
    .rd_ovf_o(rd_ovf0), .running_o(running0), .done_o(done0)
  );

  typedef struct {
    string      name;
    logic [1:0] sel;
    logic [7:0] data;
    logic       ovf;
    bit         on0;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       ovf;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic add_vec(string name, logic [1:0] sel, logic [7:0] data, logic ovf, bit on0);
    vec_t v;
    v.name = name; v.sel = sel; v.data = data; v.ovf = ovf; v.on0 = on0;
    tbl.push_back(v);
  endtask

  // Expected readout is queued when the select is driven and popped once the mux has settled.
  task automatic chk_rd(string name, logic [1:0] sel, logic [7:0] data, logic ovf, bit on0);
    exp_t e;
    e.name = name; e.data = data; e.ovf = ovf;
    sb.push_back(e);
    rd_sel_i = sel;
    #1;
    e = sb.pop_front();
    $display("rd %s sel=%0d data=%0d ovf=%0d", e.name, sel,
             on0 ? rd_data0 : rd_data, on0 ? rd_ovf0 : rd_ovf);
    check_val({e.name, "_data"}, on0 ? rd_data0 : rd_data, e.data);
    check_val({e.name, "_ovf"}, on0 ? rd_ovf0 : rd_ovf, e.ovf);
  endtask

  task automatic run_tbl(int lo, int hi);
    for (int i = lo; i <= hi; i++)
      chk_rd(tbl[i].name, tbl[i].sel, tbl[i].data, tbl[i].ovf, tbl[i].on0);
  endtask

  task automatic cycle(logic s, logic [1:0] e, logic sn, logic cl);
    start_i = s; evt_i = e; snap_i = sn; clear_i = cl;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    start_i = 1'b0; clear_i = 1'b0; snap_i = 1'b0; evt_i = 2'b00; rd_sel_i = 2'd0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    add_vec("t1_cyc",  2'd0, 8'd30,  1'b0, 1'b0);
    add_vec("t1_e0",   2'd1, 8'd10,  1'b0, 1'b0);
    add_vec("t1_e1",   2'd2, 8'd0,   1'b0, 1'b0);
    add_vec("t1_sel3", 2'd3, 8'd0,   1'b0, 1'b0);
    add_vec("t3_cyc",  2'd0, 8'd255, 1'b1, 1'b1);
    add_vec("t3_e0",   2'd1, 8'd255, 1'b1, 1'b1);
    add_vec("t3_e1",   2'd2, 8'd255, 1'b1, 1'b1);
    add_vec("t3c_cyc", 2'd0, 8'd0,   1'b0, 1'b1);
    add_vec("t3c_e0",  2'd1, 8'd0,   1'b0, 1'b1);
    add_vec("t3c_e1",  2'd2, 8'd0,   1'b0, 1'b1);

    // Reset state, sampled while reset is held
    rst_n_i = 1'b0;
    start_i = 1'b0; clear_i = 1'b0; snap_i = 1'b0; evt_i = 2'b00; rd_sel_i = 2'd0;
    repeat (2) @(posedge clk_i);
    #1;
    check_val("rst_done", done, 0);
    check_val("rst_running", running, 0);
    chk_rd("rst_cyc", 2'd0, 8'd0, 1'b0, 1'b0);
    chk_rd("rst_e1", 2'd2, 8'd0, 1'b0, 1'b0);
    rst_n_i = 1'b1;

    // 1: full run to the limit with evt0 every third cycle
    for (int c = 1; c <= 30; c++) begin
      cycle(1'b1, (c % 3 == 0) ? 2'b01 : 2'b00, 1'b0, 1'b0);
      if (c == 29) begin
        check_val("t1_done_c29", done, 0);
        check_val("t1_run_c29", running, 1);
      end
    end
    check_val("t1_done_c30", done, 1);
    check_val("t1_run_c30", running, 0);
    repeat (3) cycle(1'b1, 2'b11, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, 1'b1, 1'b0);
    run_tbl(0, 3);
    check_val("t1_done_hold", done, 1);

    // 2: pause for wall cycles 5-9 delays DONE by five cycles
    do_reset();
    for (int w = 1; w <= 35; w++) begin
      cycle((w >= 5 && w <= 9) ? 1'b0 : 1'b1, 2'b00, 1'b0, 1'b0);
      if (w == 7) check_val("t2_run_paused", running, 0);
      if (w == 34) check_val("t2_done_w34", done, 0);
    end
    check_val("t2_done_w35", done, 1);
    cycle(1'b0, 2'b00, 1'b1, 1'b0);
    chk_rd("t2_cyc", 2'd0, 8'd30, 1'b0, 1'b0);

    // 3: unlimited run saturates everything, then clear
    do_reset();
    repeat (300) cycle(1'b1, 2'b11, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, 1'b1, 1'b0);
    run_tbl(4, 6);
    check_val("t3_done0", done0, 0);
    cycle(1'b1, 2'b00, 1'b0, 1'b1);
    check_val("t3_idle_run0", running0, 0);
    check_val("t3_idle_done0", done0, 0);
    cycle(1'b0, 2'b00, 1'b1, 1'b0);
    run_tbl(7, 9);

    // 4: snapshot excludes the increment of its own edge
    do_reset();
    for (int c = 1; c <= 11; c++)
      cycle(1'b1, (c == 3 || c == 7) ? 2'b10 : 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 2'b10, 1'b1, 1'b0);
    cycle(1'b0, 2'b00, 1'b0, 1'b0);
    chk_rd("t4_cyc", 2'd0, 8'd11, 1'b0, 1'b0);
    chk_rd("t4_e1", 2'd2, 8'd2, 1'b0, 1'b0);
    chk_rd("t4_e0", 2'd1, 8'd0, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, 1'b1, 1'b0);
    chk_rd("t4_cyc_b", 2'd0, 8'd12, 1'b0, 1'b0);
    chk_rd("t4_e1_b", 2'd2, 8'd3, 1'b0, 1'b0);

    // 5: asynchronous reset between edges, then restart from one
    do_reset();
    repeat (4) cycle(1'b1, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 2'b00, 1'b1, 1'b0);
    repeat (2) cycle(1'b1, 2'b00, 1'b0, 1'b0);
    chk_rd("t5_pre", 2'd0, 8'd4, 1'b0, 1'b0);
    check_val("t5_run_pre", running, 1);
    #1 rst_n_i = 1'b0;
    #1;
    check_val("t5_rst_data", rd_data, 0);
    check_val("t5_rst_running", running, 0);
    check_val("t5_rst_done", done, 0);
    start_i = 1'b0;
    #1 rst_n_i = 1'b1;
    repeat (3) cycle(1'b1, 2'b00, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, 1'b1, 1'b0);
    chk_rd("t5_restart", 2'd0, 8'd3, 1'b0, 1'b0);

    // 6: clear with start and snap while DONE
    do_reset();
    repeat (30) cycle(1'b1, 2'b00, 1'b0, 1'b0);
    check_val("t6_done", done, 1);
    cycle(1'b1, 2'b00, 1'b1, 1'b1);
    check_val("t6_clr_done", done, 0);
    check_val("t6_clr_running", running, 0);
    start_i = 1'b0;
    chk_rd("t6_preclear_snap", 2'd0, 8'd30, 1'b0, 1'b0);
    chk_rd("t6_sel3", 2'd3, 8'd0, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, 1'b1, 1'b0);
    chk_rd("t6_cleared", 2'd0, 8'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
